// File: rtl/demux_sel_seq.sv
// demux_sel_seq: steps the 2x4 demux select through enabled channels with a programmable dwell
module demux_sel_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               enable,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);
  state_t st, nst;
  logic [3:0] mask_q;
  logic mode_q, up_ok;
  logic [DWELL_W-1:0] cnt, ncnt, rld, rld_in;
  logic [1:0] nsel, lo_in, lo_q, up;
  assign rld_in = (dwell == '0) ? '0 : dwell - ONE;
  always_comb begin
    lo_in = '0;
    lo_q = '0;
    up = '0;
    up_ok = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) lo_in = 2'(i);
      if (mask_q[i]) lo_q = 2'(i);
      if (mask_q[i] && i > int'(sel)) begin
        up = 2'(i);
        up_ok = 1'b1;
      end
    end
  end
  always_comb begin
    nst = st;
    nsel = sel;
    ncnt = cnt;
    case (st)
      IDLE: if (start) begin
        nst = |ch_mask ? ACTIVE : DONE;
        nsel = lo_in;
        ncnt = rld_in;
      end
      ACTIVE: if (stop || (cnt == '0 && !up_ok && !mode_q)) begin
        nst = DONE;
        nsel = '0;
      end else if (cnt == '0) begin
        nsel = up_ok ? up : lo_q;
        ncnt = rld;
      end else ncnt = cnt - ONE;
      default: begin
        nst = IDLE;
        nsel = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      sel <= '0;
      cnt <= '0;
      rld <= '0;
      mask_q <= '0;
      mode_q <= 1'b0;
      enable <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= nst;
      sel <= nsel;
      cnt <= ncnt;
      enable <= nst == ACTIVE;
      busy <= nst == ACTIVE;
      done <= nst == DONE;
      if (st == IDLE && start) begin
        mask_q <= ch_mask;
        mode_q <= mode;
        rld <= rld_in;
      end
    end
  end
endmodule

// File: tb/tb_demux_sel_seq.sv
// tb_demux_sel_seq: directed and random scans checked against an expected select sequence
module tb_demux_sel_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [3:0] ch_mask = '0;
  logic [7:0] dwell = '0;
  logic enable, busy, done;
  logic [1:0] sel;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  demux_sel_seq #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .ch_mask(ch_mask), .dwell(dwell), .enable(enable), .sel(sel), .busy(busy), .done(done)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {enable, sel, busy, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: en,sel,busy,done got %b want %b", tag, obs, exp);
    end
  endtask
  task automatic run_scan(input logic m, input logic [3:0] msk, input logic [7:0] dw,
                          input int stop_k, input bit pert);
    logic [1:0] q[$];
    int d, n;
    d = (dw == 0) ? 1 : int'(dw);
    do begin
      for (int i = 0; i < 4; i++)
        if (msk[i]) repeat (d) q.push_back(2'(i));
    end while (m && msk != 0 && q.size() <= stop_k);
    n = (stop_k >= 0 && stop_k < q.size()) ? stop_k + 1 : q.size();
    mode = m;
    ch_mask = msk;
    dwell = dw;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("active", {1'b1, q[k], 2'b10});
      if (pert) begin
        ch_mask = 4'($urandom);
        dwell = 8'($urandom);
        mode = 1'($urandom);
        start = 1'($urandom);
      end
      stop = (k == stop_k);
      step();
    end
    stop = 1'b0;
    chk("done", 5'b00001);
    start = 1'($urandom);
    step();
    start = 1'b0;
    chk("idle", 5'b00000);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      start = ~start;
      step();
      chk("reset", 5'b00000);
    end
    rst_n = 1'b1;
    start = 1'b0;
    step();
    chk("post_reset", 5'b00000);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop", 5'b00000);
    run_scan(1'b0, 4'b1011, 8'd3, -1, 1'b0);
    run_scan(1'b1, 4'b0110, 8'd0, 3, 1'b0);
    run_scan(1'b0, 4'b0000, 8'd4, -1, 1'b0);
    run_scan(1'b0, 4'b1111, 8'd2, -1, 1'b1);
    run_scan(1'b1, 4'b1000, 8'd2, 7, 1'b0);
    run_scan(1'b0, 4'b0100, 8'd255, -1, 1'b0);
    run_scan(1'b1, 4'b1001, 8'd1, 0, 1'b0);
    mode = 1'b0;
    ch_mask = 4'b1111;
    dwell = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_reset_sel2", 5'b11010);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_reset", 5'b00000);
    step();
    chk("mid_reset_idle", 5'b00000);
    run_scan(1'b0, 4'b1100, 8'd1, -1, 1'b0);
    for (int r = 0; r < 40; r++) begin
      logic rm;
      rm = 1'($urandom);
      run_scan(rm, 4'($urandom), 8'($urandom_range(0, 5)),
               rm ? int'($urandom_range(0, 20)) :
                    (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1), 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
